// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, wptr synchronizer, empty flag and a one-word output stage.
// Optional almost-empty output is built only when RD_AEMPTY_EN is defined.
module fifo_rd_ctrl #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [DATASIZE-1:0] rdata_mem,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                rvalid,
    input  logic                rready,
`ifdef RD_AEMPTY_EN
    output logic                raempty,
`endif
    output logic [DATASIZE-1:0] rdata
);

    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= 2**(ADDRSIZE+1)) begin : g_bad_aempty_thresh
        $error("fifo_rd_ctrl: AEMPTY_THRESH out of range");
    end

    logic [ADDRSIZE:0]   rq1_wptr_q, rq2_wptr_q;
    logic [ADDRSIZE:0]   rbin_q, rbin_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic                rempty_q, rempty_d;
    logic                rvalid_q, rvalid_d;
    logic [DATASIZE-1:0] rdata_q, rdata_d;
    logic                fetch;

`ifdef RD_AEMPTY_EN
    localparam logic [ADDRSIZE:0] AEMPTY_LIM = (ADDRSIZE+1)'(AEMPTY_THRESH);

    logic              raempty_q, raempty_d;
    logic [ADDRSIZE:0] wq_bin;
    logic [ADDRSIZE:0] unfetched;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
`endif

    always_comb begin
        // NOTE: every *_d gets a default before any branch so no path leaves it unassigned (no latch).
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        fetch    = !rempty_q && (!rvalid_q || rready);
        rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, fetch};
        rptr_d   = (rbin_d >> 1) ^ rbin_d;
        rempty_d = (rptr_d == rq2_wptr_q);

        // A consume without a refill drains the stage; a fetch always refills it.
        if (fetch) begin
            rdata_d  = rdata_mem;
            rvalid_d = 1'b1;
        end else if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
    end

`ifdef RD_AEMPTY_EN
    always_comb begin
        wq_bin    = gray2bin(rq2_wptr_q);
        unfetched = wq_bin - rbin_d;
        raempty_d = (unfetched <= AEMPTY_LIM);
    end
`endif

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            // NOTE: synchronizer flops are reset too, so rempty compares against a known pointer out of reset.
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
            rbin_q     <= '0;
            rptr_q     <= '0;
            rempty_q   <= 1'b1;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
`ifdef RD_AEMPTY_EN
            raempty_q  <= 1'b1;
`endif
        end else begin
            rq1_wptr_q <= wptr;
            rq2_wptr_q <= rq1_wptr_q;
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            rempty_q   <= rempty_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
`ifdef RD_AEMPTY_EN
            raempty_q  <= raempty_d;
`endif
        end
    end

    assign raddr  = rbin_q[ADDRSIZE-1:0];
    assign rptr   = rptr_q;
    assign rempty = rempty_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
`ifdef RD_AEMPTY_EN
    assign raempty = raempty_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl: a write-side model fills a behavioural memory and a queue scoreboard
// checks every accepted word; directed steps cover latency, wrap, backpressure, reset and almost-empty.
`timescale 1ns/1ps
module tb_fifo_rd_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TH = 2;

    logic          rclk = 1'b0;
    logic          rrst_n;
    logic          rready;
    logic [AW:0]   wptr;
    logic [DW-1:0] rdata_mem;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          rempty;
    logic          rvalid;
    logic [DW-1:0] rdata;
`ifdef RD_AEMPTY_EN
    logic          raempty;
`endif

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wbin;
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;

    fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AEMPTY_THRESH(TH)) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .wptr      (wptr),
        .rdata_mem (rdata_mem),
        .raddr     (raddr),
        .rptr      (rptr),
        .rempty    (rempty),
        .rvalid    (rvalid),
        .rready    (rready),
`ifdef RD_AEMPTY_EN
        .raempty   (raempty),
`endif
        .rdata     (rdata)
    );

    always #5 rclk = ~rclk;
    assign rdata_mem = mem[raddr];

    initial begin
        #300000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Scoreboard: a word accepted at the coming edge must be the oldest written word.
    task automatic tick();
        if (rvalid && rready) begin
            check("sb_word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("sb_data", 32'(rdata), 32'(exp_q.pop_front()));
        end
        @(posedge rclk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wbin[AW-1:0]] = d;
        wbin = wbin + 1'b1;
        wptr = gray(wbin);
        exp_q.push_back(d);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!rvalid && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(rvalid), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rempty"}, 32'(rempty), 32'd1);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_rdata"},  32'(rdata),  32'd0);
        check({tag, "_rptr"},   32'(rptr),   32'd0);
        check({tag, "_raddr"},  32'(raddr),  32'd0);
`ifdef RD_AEMPTY_EN
        check({tag, "_raempty"}, 32'(raempty), 32'd1);
`endif
    endtask

    logic          prev_rempty;
    logic [AW-1:0] prev_raddr;
    logic [AW:0]   prev_rptr;
    logic          seen_raddr_wrap;
    logic          seen_rptr_wrap;

    task automatic stream_tick();
        prev_rempty = rempty;
        prev_raddr  = raddr;
        prev_rptr   = rptr;
        tick();
        if (!prev_rempty) check("stream_no_gap", 32'(rvalid), 32'd1);
        if (prev_raddr == 4'd15 && raddr == 4'd0) seen_raddr_wrap = 1'b1;
        if (prev_rptr == 5'b10000 && rptr == 5'd0) seen_rptr_wrap = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] bw [3];
        logic [AW:0]   base;
        int            written;
        int            unfetched;

        rrst_n = 1'b0;
        rready = 1'b0;
        wbin   = '0;
        wptr   = '0;
        seen_raddr_wrap = 1'b0;
        seen_rptr_wrap  = 1'b0;
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;

        // Reset state, then release away from the clock edge.
        #12;
        check_reset_state("reset");
        @(posedge rclk);
        #3;
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        check("idle_rempty", 32'(rempty), 32'd1);

        // Single word: rvalid appears at the 4th edge after wptr changes.
        write_word(8'hA5);
        tick();
        check("lat_e1_rvalid", 32'(rvalid), 32'd0);
        tick();
        check("lat_e2_rempty", 32'(rempty), 32'd1);
        tick();
        check("lat_e3_rempty", 32'(rempty), 32'd0);
        check("lat_e3_rvalid", 32'(rvalid), 32'd0);
        tick();
        check("lat_e4_rvalid", 32'(rvalid), 32'd1);
        check("lat_e4_rdata",  32'(rdata),  32'hA5);
        check("lat_e4_rptr",   32'(rptr),   32'(gray(5'd1)));
        check("lat_e4_raddr",  32'(raddr),  32'd1);
        check("lat_e4_rempty", 32'(rempty), 32'd1);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("single_done_rvalid", 32'(rvalid), 32'd0);
        check("single_done_rempty", 32'(rempty), 32'd1);
        check("single_done_rptr",   32'(rptr),   32'd1);

        // Streaming 40 random words in random bursts, crossing both pointer wraps.
        rready  = 1'b1;
        written = 0;
        while (written < 40) begin
            int burst = int'($urandom_range(2, 6));
            for (int i = 0; i < burst && written < 40; i++) begin
                write_word(DW'($urandom));
                written++;
                stream_tick();
            end
            repeat ($urandom_range(0, 3)) stream_tick();
        end
        repeat (6) stream_tick();
        check("stream_drained",   32'(exp_q.size()),   32'd0);
        check("stream_raddr_wrap", 32'(seen_raddr_wrap), 32'd1);
        check("stream_rptr_wrap",  32'(seen_rptr_wrap),  32'd1);
        check("stream_rvalid_end", 32'(rvalid), 32'd0);

        // Backpressure: three words, consumer stalls five cycles.
        rready = 1'b0;
        base   = wbin;
        for (int i = 0; i < 3; i++) begin
            bw[i] = DW'($urandom);
            write_word(bw[i]);
            tick();
        end
        wait_valid("bp_first_valid", 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_rvalid", 32'(rvalid), 32'd1);
            check("bp_hold_rdata",  32'(rdata),  32'(bw[0]));
            check("bp_hold_rptr",   32'(rptr),   32'(gray(base + 5'd1)));
        end
        rready = 1'b1;
        tick();
        check("bp_w2_rvalid", 32'(rvalid), 32'd1);
        check("bp_w2_rdata",  32'(rdata),  32'(bw[1]));
        tick();
        check("bp_w3_rvalid", 32'(rvalid), 32'd1);
        check("bp_w3_rdata",  32'(rdata),  32'(bw[2]));
        tick();
        check("bp_end_rvalid", 32'(rvalid), 32'd0);
        rready = 1'b0;

        // Reset mid-burst with a prefetched word and five more unread.
        for (int i = 0; i < 6; i++) begin
            write_word(DW'($urandom));
            tick();
        end
        repeat (6) tick();
        check("mrst_pre_rvalid", 32'(rvalid), 32'd1);
        #3;
        rrst_n = 1'b0;
        #1;
        check_reset_state("mrst");
        wbin = '0;
        wptr = '0;
        exp_q.delete();
        #3;
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        rready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mrst_no_stale", 32'(rvalid), 32'd0);
        end
        write_word(8'h3C);
        wait_valid("mrst_new_valid", 10);
        check("mrst_new_rdata", 32'(rdata), 32'h3C);
        tick();
        check("mrst_new_rptr", 32'(rptr), 32'd1);
        rready = 1'b0;

`ifdef RD_AEMPTY_EN
        // Almost-empty: five words, one prefetched, then drain one per cycle.
        for (int i = 0; i < 5; i++) begin
            write_word(DW'($urandom));
            tick();
        end
        repeat (6) tick();
        unfetched = 4;
        check("aempty_full_level", 32'(raempty), 32'd0);
        rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (unfetched > 0) unfetched--;
            check("aempty_drain", 32'(raempty), 32'(unfetched <= TH));
        end
        repeat (3) tick();
        check("aempty_drained", 32'(exp_q.size()), 32'd0);
        rready = 1'b0;
`else
        unfetched = 0;
        check("final_queue_empty", 32'(exp_q.size() + unfetched), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
